// File: rtl/line_grid_aligner_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : line_grid_aligner_pkg
//  Brief   : State type and bus-width helper shared by the line grid aligner
//            and the serial-to-parallel converter.
//  Rev     : 1.0 - initial release
// ============================================================================
package line_grid_aligner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PASS     = 3'd1,
        ST_PAD_PX   = 3'd2,
        ST_DROP_PX  = 3'd3,
        ST_PAD_LINE = 3'd4
    } lga_state_t;

    // Pixel width rounded up to a whole number of bytes, in bits.
    function automatic int px_bus_bits(input int px_width);
        return ((px_width + 7) / 8) * 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_grid_aligner.sv
`default_nettype none
// ============================================================================
//  Module  : line_grid_aligner
//  Brief   : Forces every output line to FRAME_RES_X pixels and every frame to
//            a multiple of LINES_MULT lines by padding, truncating or
//            inserting lines in a serial AXI4-Stream video flow.
//  Rev     : 1.0 - initial release
// ============================================================================
module line_grid_aligner
    import line_grid_aligner_pkg::*;
#(
    parameter int PX_WIDTH    = 8,
    parameter int FRAME_RES_X = 1280,
    parameter int LINES_MULT  = 8,
    parameter int PAD_VALUE   = 0,
    localparam int DATA_W     = px_bus_bits(PX_WIDTH),
    localparam int KEEP_W     = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [DATA_W-1:0] video_i_tdata,
    input  logic [KEEP_W-1:0] video_i_tkeep,
    input  logic [KEEP_W-1:0] video_i_tstrb,
    input  logic              video_i_tvalid,
    input  logic              video_i_tlast,
    input  logic              video_i_tuser,
    output logic              video_i_tready,

    output logic [DATA_W-1:0] video_o_tdata,
    output logic [KEEP_W-1:0] video_o_tkeep,
    output logic [KEEP_W-1:0] video_o_tstrb,
    output logic              video_o_tvalid,
    output logic              video_o_tlast,
    output logic              video_o_tuser,
    input  logic              video_o_tready,

    input  logic              clr_i,
    output logic [15:0]       fix_cnt_o,
    output logic              sync_err_o
);

    localparam int c_px_w = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
    localparam int c_lc_w = (LINES_MULT > 1) ? $clog2(LINES_MULT) : 1;
    localparam logic [c_px_w-1:0] c_px_last = c_px_w'(FRAME_RES_X - 1);
    localparam logic [c_lc_w-1:0] c_lc_last = c_lc_w'(LINES_MULT - 1);
    localparam logic [DATA_W-1:0] c_pad     = DATA_W'(PAD_VALUE);

    lga_state_t        r_state;
    logic [c_px_w-1:0] r_px_cnt;
    logic [c_lc_w-1:0] r_line_cnt;
    logic              r_run;
    logic [15:0]       r_fix_cnt;
    logic              r_sync_err;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [KEEP_W-1:0] r_out_keep;
    logic [KEEP_W-1:0] r_out_strb;
    logic              r_out_last;
    logic              r_out_user;

    logic              w_load;
    logic              w_in_sof;
    logic              w_ready;
    logic              w_accept;
    logic              w_take_sof;
    logic              w_fwd;
    logic              w_pos_last;
    logic [c_px_w-1:0] w_pos;
    logic [c_px_w-1:0] w_px_next;
    logic [c_lc_w-1:0] w_lc_base;
    logic [c_lc_w-1:0] w_lc_next;
    logic              w_fix_inc;
    logic              w_sync_set;

    always_comb begin
        w_load   = !r_out_valid || video_o_tready;
        w_in_sof = video_i_tvalid && video_i_tuser;

        // A frame start is held off until the running frame is squared up.
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:    w_ready = w_load;
            ST_PASS:    w_ready = w_load && !(w_in_sof && (r_px_cnt != '0 || r_line_cnt != '0));
            ST_DROP_PX: w_ready = w_in_sof ? (w_load && r_line_cnt == '0) : 1'b1;
            default:    w_ready = 1'b0;
        endcase
        w_ready = w_ready && r_run;

        w_accept   = video_i_tvalid && w_ready;
        w_take_sof = w_accept && video_i_tuser;
        w_fwd      = w_accept && (r_state == ST_PASS || video_i_tuser);

        // An accepted frame start restarts the pixel/line grid at zero.
        w_pos      = w_take_sof ? '0 : r_px_cnt;
        w_pos_last = (w_pos == c_px_last);
        w_px_next  = w_pos_last ? '0 : w_pos + c_px_w'(1);
        w_lc_base  = w_take_sof ? '0 : r_line_cnt;
        w_lc_next  = (w_lc_base == c_lc_last) ? '0 : w_lc_base + c_lc_w'(1);

        w_fix_inc = 1'b0;
        if (w_fwd && (w_pos_last != video_i_tlast))
            w_fix_inc = 1'b1;
        if (r_state == ST_PASS && w_in_sof && r_px_cnt != '0)
            w_fix_inc = 1'b1;
        if (r_state == ST_PAD_LINE && w_load && w_pos_last)
            w_fix_inc = 1'b1;

        w_sync_set = 1'b0;
        if ((r_state == ST_PASS || r_state == ST_DROP_PX) && w_in_sof &&
            r_px_cnt == '0 && r_line_cnt != '0)
            w_sync_set = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_px_cnt    <= '0;
            r_line_cnt  <= '0;
            r_run       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_strb  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_load)
                r_out_valid <= 1'b0;

            case (r_state)
                ST_IDLE, ST_PASS, ST_DROP_PX: begin
                    if (w_fwd) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= video_i_tdata;
                        r_out_keep  <= video_i_tkeep;
                        r_out_strb  <= video_i_tstrb;
                        r_out_last  <= w_pos_last;
                        r_out_user  <= w_take_sof;
                        r_px_cnt    <= w_px_next;
                        r_line_cnt  <= w_pos_last ? w_lc_next : w_lc_base;
                        if (w_pos_last)
                            r_state <= video_i_tlast ? ST_PASS : ST_DROP_PX;
                        else
                            r_state <= video_i_tlast ? ST_PAD_PX : ST_PASS;
                    end else if (w_accept) begin
                        if (r_state == ST_DROP_PX && video_i_tlast)
                            r_state <= ST_PASS;
                    end else if (w_in_sof && r_state != ST_IDLE) begin
                        if (r_px_cnt != '0)
                            r_state <= ST_PAD_PX;
                        else if (r_line_cnt != '0)
                            r_state <= ST_PAD_LINE;
                    end
                end

                ST_PAD_PX, ST_PAD_LINE: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= c_pad;
                        r_out_keep  <= '1;
                        r_out_strb  <= '1;
                        r_out_last  <= w_pos_last;
                        r_out_user  <= 1'b0;
                        r_px_cnt    <= w_px_next;
                        if (w_pos_last) begin
                            r_line_cnt <= w_lc_next;
                            // Line insertion stops once the line grid wraps.
                            if (r_state == ST_PAD_PX || w_lc_next == '0)
                                r_state <= ST_PASS;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fix_cnt  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            if (clr_i)
                r_fix_cnt <= '0;
            else if (w_fix_inc && r_fix_cnt != 16'hFFFF)
                r_fix_cnt <= r_fix_cnt + 16'd1;

            if (clr_i)
                r_sync_err <= 1'b0;
            else if (w_sync_set)
                r_sync_err <= 1'b1;
        end
    end

    assign video_i_tready = w_ready;
    assign video_o_tvalid = r_out_valid;
    assign video_o_tdata  = r_out_data;
    assign video_o_tkeep  = r_out_keep;
    assign video_o_tstrb  = r_out_strb;
    assign video_o_tlast  = r_out_last;
    assign video_o_tuser  = r_out_user;
    assign fix_cnt_o      = r_fix_cnt;
    assign sync_err_o     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_line_grid_aligner.sv
`default_nettype none
// ============================================================================
//  Module  : tb_line_grid_aligner
//  Brief   : Self-checking bench for line_grid_aligner (16 px lines, 8-line grid).
//  Rev     : 1.0 - initial release
// ============================================================================
module tb_line_grid_aligner;

    localparam int RES  = 16;
    localparam int MULT = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       user;
        logic       last;
    } beat_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] video_i_tdata = '0;
    logic       video_i_tkeep = 1'b1;
    logic       video_i_tstrb = 1'b1;
    logic       video_i_tvalid = 1'b0;
    logic       video_i_tlast = 1'b0;
    logic       video_i_tuser = 1'b0;
    logic       video_i_tready;
    logic [7:0] video_o_tdata;
    logic       video_o_tkeep;
    logic       video_o_tstrb;
    logic       video_o_tvalid;
    logic       video_o_tlast;
    logic       video_o_tuser;
    logic       video_o_tready = 1'b1;
    logic       clr_i = 1'b0;
    logic [15:0] fix_cnt_o;
    logic       sync_err_o;

    int    n_assert = 0;
    int    n_fail   = 0;
    bit    bp_en    = 1'b0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    // Reference model state: frame membership, lines seen, expected status.
    bit m_in_frame = 1'b0;
    int m_lines    = 0;
    int m_fix      = 0;
    bit m_sync     = 1'b0;

    line_grid_aligner #(
        .PX_WIDTH    (8),
        .FRAME_RES_X (RES),
        .LINES_MULT  (MULT),
        .PAD_VALUE   (0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .video_i_tdata  (video_i_tdata),
        .video_i_tkeep  (video_i_tkeep),
        .video_i_tstrb  (video_i_tstrb),
        .video_i_tvalid (video_i_tvalid),
        .video_i_tlast  (video_i_tlast),
        .video_i_tuser  (video_i_tuser),
        .video_i_tready (video_i_tready),
        .video_o_tdata  (video_o_tdata),
        .video_o_tkeep  (video_o_tkeep),
        .video_o_tstrb  (video_o_tstrb),
        .video_o_tvalid (video_o_tvalid),
        .video_o_tlast  (video_o_tlast),
        .video_o_tuser  (video_o_tuser),
        .video_o_tready (video_o_tready),
        .clr_i          (clr_i),
        .fix_cnt_o      (fix_cnt_o),
        .sync_err_o     (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk_i) begin
        #2;
        video_o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    beat_t mon_cur;
    beat_t mon_prev;
    bit    mon_stall = 1'b0;

    always @(negedge clk_i) begin
        mon_cur = {video_o_tdata, video_o_tkeep, video_o_tuser, video_o_tlast};
        if (rst_i) begin
            mon_stall = 1'b0;
        end else begin
            if (mon_stall) begin
                check("stall_valid", 32'(video_o_tvalid), 32'd1);
                check("stall_payload", 32'(mon_cur), 32'(mon_prev));
            end
            if (video_o_tvalid && video_o_tready)
                obs_q.push_back(mon_cur);
            mon_stall = video_o_tvalid && !video_o_tready;
            mon_prev  = mon_cur;
        end
    end

    // Entered and left on a falling edge; the handshake completes on the rising edge between.
    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        int guard = 0;
        video_i_tdata  = d;
        video_i_tuser  = u;
        video_i_tlast  = l;
        video_i_tvalid = 1'b1;
        #1;
        while (!video_i_tready && guard < 2000) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        check("send_timeout", 32'(guard < 2000), 32'd1);
        @(negedge clk_i);
        video_i_tvalid = 1'b0;
        video_i_tuser  = 1'b0;
        video_i_tlast  = 1'b0;
    endtask

    task automatic push_pad_line(input int from_px);
        for (int p = from_px; p < RES; p++)
            exp_q.push_back(beat_t'({8'h00, 1'b1, 1'b0, 1'(p == RES - 1)}));
    endtask

    task automatic send_line(input int n, input bit sof, input bit term, input bit lat);
        logic [7:0] d;
        if (sof) begin
            if (m_in_frame && (m_lines % MULT) != 0) begin
                for (int k = 0; k < MULT - (m_lines % MULT); k++) begin
                    push_pad_line(0);
                    m_fix++;
                end
                m_sync = 1'b1;
            end
            m_in_frame = 1'b1;
            m_lines    = 0;
        end
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            send_beat(d, sof && i == 0, term && i == n - 1);
            if (lat && i == 0) begin
                check("latency_valid", 32'(video_o_tvalid), 32'd1);
                check("latency_tuser", 32'(video_o_tuser), 32'd1);
                check("latency_data", 32'(video_o_tdata), 32'(d));
            end
            if (m_in_frame && i < RES)
                exp_q.push_back(beat_t'({d, 1'b1, 1'(sof && i == 0), 1'(i == RES - 1)}));
        end
        if (m_in_frame) begin
            push_pad_line(n);
            if (n != RES || !term)
                m_fix++;
            m_lines++;
        end
    endtask

    task automatic drain_compare(input string tag);
        int guard = 0;
        while (obs_q.size() < exp_q.size() && guard < 5000) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        repeat (6) @(negedge clk_i);
        #1;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
        @(negedge clk_i);
        check({tag, "_fix_cnt"}, 32'(fix_cnt_o), 32'(m_fix));
        check({tag, "_sync_err"}, 32'(sync_err_o), 32'(m_sync));
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i  = 1'b0;
        m_fix  = 0;
        m_sync = 1'b0;
        check("clr_fix_cnt", 32'(fix_cnt_o), 32'd0);
        check("clr_sync_err", 32'(sync_err_o), 32'd0);
    endtask

    initial begin
        int nlines;
        int n;
        bit term;

        repeat (3) @(negedge clk_i);
        check("rst_tvalid", 32'(video_o_tvalid), 32'd0);
        check("rst_tready", 32'(video_i_tready), 32'd0);
        check("rst_fix_cnt", 32'(fix_cnt_o), 32'd0);
        check("rst_sync_err", 32'(sync_err_o), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(negedge clk_i);

        // Stray beats before any frame start are discarded.
        send_line(3, 1'b0, 1'b1, 1'b0);
        send_line(5, 1'b0, 1'b0, 1'b0);

        // Clean 16x16 frame.
        send_line(RES, 1'b1, 1'b1, 1'b1);
        for (int l = 1; l < 16; l++)
            send_line(RES, 1'b0, 1'b1, 1'b0);
        drain_compare("clean");

        // Early tlast on line 3.
        for (int l = 0; l < MULT; l++)
            send_line((l == 3) ? 10 : RES, l == 0, 1'b1, 1'b0);
        drain_compare("short_line");
        do_clear();

        // Over-long line 5.
        for (int l = 0; l < MULT; l++)
            send_line((l == 5) ? 20 : RES, l == 0, 1'b1, 1'b0);
        drain_compare("long_line");
        do_clear();

        // 11-line frame followed by a new frame start.
        for (int l = 0; l < 11; l++)
            send_line(RES, l == 0, 1'b1, 1'b0);
        drain_compare("frame11");
        send_line(RES, 1'b1, 1'b1, 1'b0);
        drain_compare("pad_lines");
        for (int l = 1; l < MULT; l++)
            send_line(RES, 1'b0, 1'b1, 1'b0);
        drain_compare("after_pad");
        do_clear();

        // Randomized frames under 50% output backpressure.
        bp_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            nlines = $urandom_range(1, 20);
            for (int l = 0; l < nlines; l++) begin
                n    = ($urandom_range(0, 9) < 7) ? RES : $urandom_range(1, 24);
                term = (l == nlines - 1 && f < 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
                send_line(n, l == 0, term, 1'b0);
            end
        end
        drain_compare("random");
        do_clear();

        // Reset in the middle of line 2 under backpressure.
        send_line(RES, 1'b1, 1'b1, 1'b0);
        send_line(RES, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            send_beat(8'($urandom), 1'b0, 1'b0);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        obs_q.delete();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_lines    = 0;
        m_fix      = 0;
        m_sync     = 1'b0;
        @(negedge clk_i);
        check("midrst_tvalid", 32'(video_o_tvalid), 32'd0);
        check("midrst_tready", 32'(video_i_tready), 32'd0);
        check("midrst_fix_cnt", 32'(fix_cnt_o), 32'd0);
        check("midrst_sync_err", 32'(sync_err_o), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(negedge clk_i);
        for (int i = 5; i < RES; i++)
            send_beat(8'($urandom), 1'b0, 1'(i == RES - 1));
        send_line(RES, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk_i);
        #1;
        check("post_rst_silent", 32'(obs_q.size()), 32'd0);
        check("post_rst_tvalid", 32'(video_o_tvalid), 32'd0);
        @(negedge clk_i);
        for (int l = 0; l < MULT; l++)
            send_line(RES, l == 0, 1'b1, 1'b0);
        drain_compare("post_rst_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_grid_aligner.md
LINE_GRID_ALIGNER -- requirements
Module: line_grid_aligner

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter FRAME_RES_X, default 1280, required pixels per output line.
REQ-003 SHALL have parameter LINES_MULT, default 8, output line count per frame forced to a multiple of this value.
REQ-004 SHALL have parameter PAD_VALUE, default 0, pixel value emitted for inserted pixels.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port video_i, axi4_stream_if.slave, TDATA = PX_WIDTH rounded up to bytes, serial video (tuser = start of frame, tlast = end of line).
REQ-008 SHALL have port video_o, axi4_stream_if.master, same widths, line/frame-aligned video for the serial-to-parallel converter.
REQ-009 SHALL have port clr_i, input, 1, synchronous clear of status counters and flags.
REQ-010 SHALL have port fix_cnt_o, output, 16, saturating count of corrected lines (padded, truncated or inserted).
REQ-011 SHALL have port sync_err_o, output, 1, sticky flag: frame ended with line count not a multiple of LINES_MULT.

Function
REQ-012 SHALL provide one output register stage; it loads when !video_o.tvalid || video_o.tready; latency 1 cycle, full throughput in PASS.
REQ-013 SHALL implement the states IDLE, PASS, PAD_PX, DROP_PX and PAD_LINE.
REQ-014 IDLE: video_i.tready=1; beats with tuser=0 are discarded; a beat with tuser=1 is forwarded and the FSM enters PASS with px_cnt=1 and line_cnt=0.
REQ-015 PASS: forward beats; px_cnt increments per accepted beat; output tlast=1 exactly when px_cnt==FRAME_RES_X-1, then px_cnt wraps to 0 and line_cnt (mod LINES_MULT) increments.
REQ-016 Early input tlast (px_cnt<FRAME_RES_X-1): the beat is forwarded with tlast=0, then PAD_PX with video_i.tready=0 emits PAD_VALUE beats until output tlast at FRAME_RES_X-1.
REQ-017 Missing input tlast at px_cnt==FRAME_RES_X-1: output tlast is forced; then DROP_PX with video_i.tready=1 discards beats up to and including the input tlast.
REQ-018 An input beat with tuser=1 seen in PASS or DROP_PX SHALL NOT be accepted (tready=0); if px_cnt!=0, the current line is first completed via PAD_PX; then, if line_cnt!=0, PAD_LINE emits (LINES_MULT-line_cnt) full pad lines; then the tuser beat is accepted as in IDLE.
REQ-019 Output tuser SHALL be 1 only on the first beat of a frame; inserted beats SHALL carry tuser=0, tkeep/tstrb all ones, and tdata=PAD_VALUE.
REQ-020 fix_cnt_o SHALL increment once per line that is padded, truncated or inserted, saturate at 16'hFFFF, and clear on clr_i.
REQ-021 sync_err_o SHALL set on every entry to PAD_LINE and clear only on clr_i or reset.
REQ-022 When clr_i and an increment occur in the same cycle, clr_i SHALL win.
REQ-023 Output tvalid SHALL NOT drop, and its payload SHALL NOT change, while tready=0.
REQ-024 px_cnt width SHALL be $clog2(FRAME_RES_X); line_cnt width SHALL be $clog2(LINES_MULT), or 1 bit when LINES_MULT==1.

Reset
REQ-025 On rst_i: state=IDLE, px_cnt=0, line_cnt=0, video_o.tvalid=0, video_i.tready=0, fix_cnt_o=0, sync_err_o=0.
REQ-026 Reset asserted mid-line SHALL drop the partial output immediately; after release, output starts only at the next input tuser.

Structure
REQ-027 The shared package SHALL hold the state enum typedef and the byte-rounding width function shared with the serial-to-parallel converter.
REQ-028 SHALL be a single module with no sub-module; the output register SHALL be inline.

Verification (FRAME_RES_X=16, LINES_MULT=8, PAD_VALUE=0)
REQ-029 Clean frame of 16 lines x 16 px, tready=1 -> identical output, 1-cycle latency, fix_cnt_o=0, sync_err_o=0.
REQ-030 Line 3 carries tlast at px 9 -> px 0..9 passed, 6 beats of 0 appended, tlast at px 15, fix_cnt_o=1.
REQ-031 Line 5 is 20 px long -> tlast forced at px 15, 4 px dropped, next line aligned, fix_cnt_o=1.
REQ-032 Frame of 11 lines followed by tuser -> 5 pad lines (80 beats of 0) inserted before the new tuser, sync_err_o=1, fix_cnt_o=5.
REQ-033 Random tready backpressure at 50% plus reset asserted mid-line 2 -> no payload change under stall; after reset, output is silent until the next tuser; counters are 0.
